bus_grant_seq: RTL
==================

// Module: bus_grant_seq
// PURPOSE
//  Sequences the 68k-style BR/BG/BGACK handshake between external (host-side) DMA masters and the accelerator CPU.
//  Synchronises async BR/BGACK into the CLKCPU domain. Issues BG20 only when AS20 and AS_INT agree, so no grant
//  goes out while bus-cycle ownership is ambiguous. Tracks external tenure and enforces a release holdoff.
// PARAMETERS
//  SYNC_STAGES  2    flops per async input synchroniser (BR, BGACK); legal 2..4
//  HOLDOFF      3    CLKCPU cycles after BGACK negation before a new request is honoured; legal 1..15
//  ACK_TIMEOUT  255  cycles in GRANT with no BGACK before BG is withdrawn (ARB_WATCHDOG_EN only); 8-bit
// PORTS
//  CLKCPU         in   1  CPU clock; all state on rising edge
//  RESET          in   1  asynchronous, active-low reset
//  BR             in   1  external bus request, active-low, asynchronous
//  BGACK          in   1  external bus grant acknowledge, active-low, asynchronous
//  AS20           in   1  CPU-side address strobe, active-low (CLKCPU domain)
//  AS_INT         in   1  host-side address strobe, active-low (CLKCPU domain)
//  BG20           out  1  bus grant to CPU, active-low, registered
//  BGACK_INT      out  1  synchronised BGACK, active-low
//  BUS_OWNED      out  1  high while external master owns the bus (CPU-side drivers tristated)
//  GRANT_TIMEOUT  out  1  one-cycle pulse on watchdog expiry; constant 0 without ARB_WATCHDOG_EN
//  STATE          out  3  current state encoding (debug)
// BEHAVIOUR
//  Reset (RESET=0, async): BG20=1, BGACK_INT=1, BUS_OWNED=0, GRANT_TIMEOUT=0, STATE=IDLE.
//   Sync flops preset to 1 (negated), all counters 0. Reset mid-tenure drops the grant immediately.
//  br_s/bgack_s = last synchroniser stage; BGACK_INT = bgack_s.
//  States (STATE code):
//   IDLE(0)  : BG20=1. bgack_s=0 -> OWNED (unsolicited takeover). Else br_s=0 -> QUIET.
//   QUIET(1) : BG20=1. 1-bit match counter, cleared on entry, cleared on any cycle AS20!=AS_INT.
//              Second consecutive matching cycle -> GRANT. br_s=1 -> IDLE (request withdrawn). bgack_s=0 -> OWNED.
//   GRANT(2) : BG20=0. bgack_s=0 -> OWNED. Else br_s=1 -> IDLE (BG withdrawn).
//              If both in the same cycle, bgack_s wins.
//   OWNED(3) : BG20=1, BUS_OWNED=1. br_s ignored. bgack_s=1 -> HOLD.
//   HOLD(4)  : BG20=1, BUS_OWNED=0. 4-bit counter runs HOLDOFF cycles, ignoring BR, then -> IDLE.
//              bgack_s=0 during HOLD -> OWNED (re-acquire).
//   Codes 5-7 unreachable; decode to IDLE next cycle.
//  BG20 and BUS_OWNED are registered from next-state: they change on the edge that enters the state.
//  Latency: BR low (AS20==AS_INT held) -> BG20 low on the (SYNC_STAGES+3)th rising edge; 5 at default.
//  BGACK low in GRANT -> BG20 high and BUS_OWNED high on the (SYNC_STAGES+1)th edge.
//  BGACK high in OWNED -> BUS_OWNED low after SYNC_STAGES+1 edges. BR is re-sampled HOLDOFF cycles later.
//  AS20/AS_INT mismatch never blocks OWNED or HOLD exits. It only gates QUIET->GRANT.
// CONFIGURATION
//  ARB_WATCHDOG_EN defined: an 8-bit counter clears on GRANT entry and increments each GRANT cycle.
//   On reaching ACK_TIMEOUT with bgack_s=1: BG20->1, GRANT_TIMEOUT=1 for one cycle, -> HOLD.
//   A still-asserted BR then retries after the holdoff.
//  ARB_WATCHDOG_EN undefined: no counter. GRANT holds until BGACK or BR negation. GRANT_TIMEOUT tied 0.
// TESTING
//  1 Reset: RESET=0 mid-OWNED -> same-cycle async BG20=1, BUS_OWNED=0, STATE=0. Release -> stays IDLE with BR=1.
//  2 Normal tenure: AS20=AS_INT=1, BR=0 -> BG20=0 at edge 5. BGACK=0 -> BG20=1, BUS_OWNED=1 at edge 3.
//    BGACK=1 -> BUS_OWNED=0. BR still 0 -> BG20=0 again no earlier than 3 cycles (HOLDOFF) after HOLD entry.
//  3 Ambiguous strobes: BR=0 with AS20=0, AS_INT=1 for 20 cycles -> BG20 stays 1, STATE=1. Set AS_INT=0 -> BG20=0 two edges later.
//  4 Withdrawn request: BR=0 until GRANT, then BR=1 with BGACK=1 -> BG20=1 SYNC_STAGES+1 edges later, STATE=0, BUS_OWNED never 1.
//  5 Race: in GRANT, BR=1 and BGACK=0 on the same edge -> STATE=3, BUS_OWNED=1.
//  6 Watchdog (ARB_WATCHDOG_EN): BR=0, BGACK=1 held -> 255 cycles after GRANT entry BG20=1, GRANT_TIMEOUT one-cycle pulse, STATE=4.
//    Then retry to GRANT. Without the macro: BG20 stays 0 for 1000 cycles, GRANT_TIMEOUT=0.

Source files
------------

// File: rtl/bus_grant_seq.sv
// bus_grant_seq
//   Sequences the 68k-style BR/BG/BGACK handshake between external DMA masters and
//   the accelerator CPU. BR and BGACK are synchronised into the CLKCPU domain. A grant
//   is issued only after AS20 and AS_INT have agreed for two consecutive cycles. The
//   block tracks external bus tenure and enforces a release holdoff before the next
//   request is honoured.
//
//   Optional feature macro: ARB_WATCHDOG_EN
//     defined   : a grant not acknowledged within ACK_TIMEOUT cycles is withdrawn,
//                 GRANT_TIMEOUT pulses for one cycle, and the FSM enters the holdoff.
//     undefined : a grant holds until BGACK or BR negation; GRANT_TIMEOUT is tied 0.
//
// Ports
//   CLKCPU        in   CPU clock, all state on the rising edge
//   RESET         in   asynchronous active-low reset
//   BR            in   external bus request, active-low, asynchronous
//   BGACK         in   external grant acknowledge, active-low, asynchronous
//   AS20          in   CPU-side address strobe, active-low
//   AS_INT        in   host-side address strobe, active-low
//   BG20          out  bus grant to CPU, active-low, registered
//   BGACK_INT     out  synchronised BGACK, active-low
//   BUS_OWNED     out  high while the external master owns the bus
//   GRANT_TIMEOUT out  one-cycle pulse on watchdog expiry
//   STATE         out  current state code (debug)
module bus_grant_seq #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned HOLDOFF     = 3,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic       CLKCPU,
    input  logic       RESET,
    input  logic       BR,
    input  logic       BGACK,
    input  logic       AS20,
    input  logic       AS_INT,
    output logic       BG20,
    output logic       BGACK_INT,
    output logic       BUS_OWNED,
    output logic       GRANT_TIMEOUT,
    output logic [2:0] STATE
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("bus_grant_seq: SYNC_STAGES must be 2..4");
    end
    if (HOLDOFF < 1 || HOLDOFF > 15) begin : g_bad_holdoff
        $error("bus_grant_seq: HOLDOFF must be 1..15");
    end
    if (ACK_TIMEOUT < 1 || ACK_TIMEOUT > 255) begin : g_bad_timeout
        $error("bus_grant_seq: ACK_TIMEOUT must be 1..255");
    end

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        QUIET = 3'd1,
        GRANT = 3'd2,
        OWNED = 3'd3,
        HOLD  = 3'd4
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(HOLDOFF - 1);

    state_t                 state;
    state_t                 state_next;
    logic [SYNC_STAGES-1:0] br_sync;
    logic [SYNC_STAGES-1:0] bgack_sync;
    logic                   br_s;
    logic                   bgack_s;
    logic                   match_cnt;
    logic [3:0]             hold_cnt;
    logic                   strobes_agree;

`ifdef ARB_WATCHDOG_EN
    localparam logic [7:0] WD_LAST = 8'(ACK_TIMEOUT - 1);
    logic [7:0] wd_cnt;
    logic       wd_expire;
`endif

    assign br_s          = br_sync[SYNC_STAGES-1];
    assign bgack_s       = bgack_sync[SYNC_STAGES-1];
    assign strobes_agree = (AS20 == AS_INT);
    assign BGACK_INT     = bgack_s;
    assign STATE         = state;

    // Synchronisers preset to the negated level so reset never looks like a request.
    always_ff @(posedge CLKCPU or negedge RESET) begin
        if (!RESET) begin
            br_sync    <= '1;
            bgack_sync <= '1;
        end else begin
            br_sync    <= {br_sync[SYNC_STAGES-2:0], BR};
            bgack_sync <= {bgack_sync[SYNC_STAGES-2:0], BGACK};
        end
    end

    // BGACK takes priority over BR everywhere: an acknowledge always wins a race.
    always_comb begin
        state_next = state;
`ifdef ARB_WATCHDOG_EN
        wd_expire  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!bgack_s)    state_next = OWNED;
                else if (!br_s)  state_next = QUIET;
            end
            QUIET: begin
                if (!bgack_s)                         state_next = OWNED;
                else if (br_s)                        state_next = IDLE;
                else if (strobes_agree && match_cnt)  state_next = GRANT;
            end
            GRANT: begin
                if (!bgack_s)    state_next = OWNED;
                else if (br_s)   state_next = IDLE;
`ifdef ARB_WATCHDOG_EN
                else if (wd_cnt == WD_LAST) begin
                    state_next = HOLD;
                    wd_expire  = 1'b1;
                end
`endif
            end
            OWNED: begin
                if (bgack_s)     state_next = HOLD;
            end
            HOLD: begin
                if (!bgack_s)                 state_next = OWNED;
                else if (hold_cnt == HOLD_LAST) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they move on the entry edge.
    always_ff @(posedge CLKCPU or negedge RESET) begin
        if (!RESET) begin
            state     <= IDLE;
            BG20      <= 1'b1;
            BUS_OWNED <= 1'b0;
            match_cnt <= 1'b0;
            hold_cnt  <= '0;
        end else begin
            state     <= state_next;
            BG20      <= (state_next != GRANT);
            BUS_OWNED <= (state_next == OWNED);
            match_cnt <= (state == QUIET) && (state_next == QUIET) && strobes_agree;
            hold_cnt  <= ((state == HOLD) && (state_next == HOLD)) ? hold_cnt + 4'd1 : '0;
        end
    end

`ifdef ARB_WATCHDOG_EN
    always_ff @(posedge CLKCPU or negedge RESET) begin
        if (!RESET) begin
            wd_cnt        <= '0;
            GRANT_TIMEOUT <= 1'b0;
        end else begin
            wd_cnt        <= ((state == GRANT) && (state_next == GRANT)) ? wd_cnt + 8'd1 : '0;
            GRANT_TIMEOUT <= wd_expire;
        end
    end
`else
    assign GRANT_TIMEOUT = 1'b0;
`endif

endmodule
